// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch into a small PC/instruction
// buffer, with redirect flush and draining of stale in-flight responses.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        misalign_err
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    logic [63:0]  fetch_pc_q, fetch_pc_d;
    logic [63:0]  rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          misalign_q, misalign_d;
    logic          active_q;
    fetch_entry_t  fifo_q [FIFO_DEPTH];

    logic req_fire, rsp_stale, push, pop;
    logic [CW:0] credit_used;

    // Requests stay off for the first cycle after reset release and during a redirect.
    assign credit_used    = (CW+1)'(outstanding_q) + (CW+1)'(count_q);
    assign imem_req_valid = active_q && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_stale = (drop_cnt_q != '0);
    assign push      = imem_rsp_valid && !rsp_stale && !redirect_valid;
    assign inst_valid = (count_q != '0);
    assign pop       = inst_valid && inst_ready;

    assign inst_out     = fifo_q[rd_ptr_q].inst;
    assign inst_pc      = fifo_q[rd_ptr_q].pc;
    assign misalign_err = misalign_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        misalign_d    = misalign_q;

        if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
        if (imem_rsp_valid && rsp_stale) drop_cnt_d = drop_cnt_q - CW'(1);
        if (push) begin
            rsp_pc_d = rsp_pc_q + 64'd4;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        // Redirect wins: everything still in flight becomes stale and the buffer is emptied.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[63:2], 2'b00};
            rsp_pc_d   = {redirect_pc[63:2], 2'b00};
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
            count_d    = '0;
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = wr_ptr_q;
            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            misalign_q    <= 1'b0;
            active_q      <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            misalign_q    <= misalign_d;
            active_q      <= 1'b1;
            if (push) fifo_q[wr_ptr_q] <= '{pc: rsp_pc_q, inst: imem_rsp_data};
        end
    end

    // Protocol checks: no response into a full buffer, no response without a request.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_rsp_valid && count_q == CW'(FIFO_DEPTH)));
            assert (!(imem_rsp_valid && outstanding_q == '0));
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: in-order memory model with random latency and a
// queue-based model of the expected instruction stream, tagged by redirect epoch.
module tb_if_fetch_unit;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        misalign_err;

    if_fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_fifo[$];
    logic [63:0] m_req_pc;
    bit          m_mis;
    int          epoch, cyc, lat_max;
    int          n_vec, n_err;

    function automatic logic [31:0] inst_of(logic [63:0] a);
        logic [31:0] w;
        w = a[33:2];
        return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset(int hold);
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'($urandom_range(1));
        imem_rsp_data = $urandom;
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'(0));
        check("rst_req_addr", imem_req_addr, 64'h0);
        check("rst_inst_valid", 64'(inst_valid), 64'(0));
        check("rst_inst_out", 64'(inst_out), 64'(0));
        check("rst_inst_pc", inst_pc, 64'h0);
        check("rst_misalign", 64'(misalign_err), 64'(0));
        mem_q.delete();
        exp_fifo.delete();
        m_req_pc = 64'h0;
        m_mis = 1'b0;
        epoch++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            imem_rsp_valid = 1'($urandom_range(1));
            imem_rsp_data = $urandom;
            #1;
            check("rst_hold_req_valid", 64'(imem_req_valid), 64'(0));
            check("rst_hold_inst_valid", 64'(inst_valid), 64'(0));
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        rst_n = 1'b1;
        // The edge following release only arms the request path; nothing is exchanged.
    endtask

    task automatic step(int p_rr, int p_ir, int p_rsp, int p_redir);
        bit          exp_rv, pop;
        mreq_t       r;
        logic [63:0] tgt;
        @(negedge clk);
        imem_req_ready = ($urandom_range(99) < p_rr);
        inst_ready     = ($urandom_range(99) < p_ir);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirect_valid = ($urandom_range(99) < p_redir);
        case ($urandom_range(7))
            0:       tgt = 64'hFFFF_FFFF_FFFF_FFF4;
            1:       tgt = 64'($urandom_range(1023));
            default: tgt = 64'($urandom_range(1023)) & ~64'h3;
        endcase
        redirect_pc = tgt;
        #1;
        exp_rv = !redirect_valid && (mem_q.size() + exp_fifo.size() < DEPTH);
        check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        check("req_addr", imem_req_addr, m_req_pc);
        check("inst_valid", 64'(inst_valid), 64'(exp_fifo.size() > 0));
        if (exp_fifo.size() > 0) begin
            check("inst_pc", inst_pc, exp_fifo[0]);
            check("inst_out", 64'(inst_out), 64'(inst_of(exp_fifo[0])));
        end
        check("misalign_err", 64'(misalign_err), 64'(m_mis));

        pop = (exp_fifo.size() > 0) && inst_ready;
        if (pop) void'(exp_fifo.pop_front());
        if (imem_rsp_valid) begin
            r = mem_q.pop_front();
            if (!redirect_valid && r.epoch == epoch) exp_fifo.push_back(r.addr);
        end
        if (exp_rv && imem_req_ready) begin
            r.addr  = m_req_pc;
            r.epoch = epoch;
            r.due   = cyc + 1 + $urandom_range(lat_max);
            mem_q.push_back(r);
            m_req_pc = m_req_pc + 64'd4;
        end
        if (redirect_valid) begin
            exp_fifo.delete();
            epoch++;
            m_req_pc = {redirect_pc[63:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        n_vec = 0; n_err = 0; epoch = 0; cyc = 0; lat_max = 0;
        m_req_pc = '0; m_mis = 1'b0;
        do_reset(2);

        // Streaming with a single-cycle memory and an always-ready datapath.
        for (int i = 0; i < 60; i++) step(100, 100, 100, 0);
        // Datapath stalls: buffer fills and requests stop, then resume.
        for (int i = 0; i < 30; i++) step(100, 0, 100, 0);
        for (int i = 0; i < 20; i++) step(100, 100, 100, 0);
        // Memory not ready: request must hold.
        for (int i = 0; i < 8; i++) step(0, 100, 100, 0);
        for (int i = 0; i < 20; i++) step(100, 100, 100, 0);

        // Random latency, backpressure and redirects (aligned, misaligned, wrapping).
        lat_max = 3;
        for (int i = 0; i < 1500; i++) step(70, 60, 80, 5);

        // Reset in the middle of traffic, then more random traffic.
        do_reset(3);
        for (int i = 0; i < 300; i++) step(75, 65, 75, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the single-cycle RV64I datapath.
- Owns the fetch PC and issues in-order 32-bit fetch requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PC in a FIFO and presents them as inst_out (drives the datapath IM_out) with valid/ready.
- Accepts a redirect (taken branch target) that flushes the buffer and discards in-flight stale responses.

Parameters:
- RESET_PC, 64'h0, fetch address after reset; must be 4-byte aligned.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2; also bounds outstanding requests.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  byte address of fetch, bits[1:0]=0.
- imem_rsp_valid  in  1  response valid; in-order, always accepted, no ready.
- imem_rsp_data  in  32  fetched instruction.
- inst_valid  out  1  inst_out/inst_pc valid.
- inst_ready  in  1  datapath consumes instruction.
- inst_out  out  32  instruction to datapath.
- inst_pc  out  64  PC of inst_out.
- redirect_valid  in  1  one-cycle redirect pulse.
- redirect_pc  in  64  new fetch address.
- misalign_err  out  1  sticky flag: redirect_pc[1:0]!=0 was seen.

Behaviour:
- Reset (async assert, sync deassert use): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, misalign_err=0, imem_req_valid=0, inst_valid=0, inst_out=0, inst_pc=0.
- Reset mid-operation: all state and in-flight tracking cleared; responses arriving while rst_n=0 are ignored.
- Credit rule: imem_req_valid=1 iff (outstanding + fifo_count) < FIFO_DEPTH and redirect_valid=0.
- Credit rule (buffer): the FIFO can never overflow; any response arriving with the FIFO full is a protocol error (assertion).
- Request handshake: imem_req_addr=fetch_pc. On valid&&ready, fetch_pc += 4 (64-bit wrap) and outstanding += 1.
- Request stability: once asserted, valid and addr hold until ready, except that a redirect retracts the request.
- Response, non-stale (drop_cnt==0): push {rsp_pc, imem_rsp_data}, rsp_pc += 4, outstanding -= 1.
- Response, stale (drop_cnt>0): discard, drop_cnt -= 1, outstanding -= 1.
- Simultaneous request accept and response: outstanding unchanged.
- Output: FIFO head drives inst_out/inst_pc/inst_valid. Pop on inst_valid&&inst_ready.
- Output latency: a response received at edge N is visible at inst_valid after edge N (registered), i.e. usable in cycle N+1. No combinational path rsp→inst.
- Simultaneous push and pop: both occur and count is unchanged. Push to an empty FIFO with inst_ready=1 appears the next cycle, not in the same cycle.
- Head stability: inst_out/inst_pc hold while inst_valid && !inst_ready.
- Redirect (highest priority) in cycle R:
  - FIFO flushed, so inst_valid=0 from R+1.
  - No request issued in R.
  - fetch_pc and rsp_pc set to {redirect_pc[63:2],2'b00}.
  - drop_cnt = outstanding - (stale rsp in R ? 1 : 0) + (req accepted in R ? 1 : 0); the last term is 0 because no request issues in R.
  - A response in R is discarded.
  - A pop in R is honoured (datapath consumed it).
  - If redirect_pc[1:0]!=0, misalign_err set (cleared only by reset).
- Back-to-back redirects: each recomputes drop_cnt from current outstanding; the last target wins.
- Effective states: RUN (drop_cnt==0) and DRAIN (drop_cnt>0). New requests may issue during DRAIN because responses are in-order and the stale ones precede them.
- Counter widths: outstanding and drop_cnt are $clog2(FIFO_DEPTH)+1 bits and never underflow (assertion).

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory, inst_ready=1 → addrs 0,4,8,… each cycle; inst_pc 0,4,8 in order with the matching rsp data; never more than 4 requests in flight.
- inst_ready=0 held with FIFO_DEPTH=4 → exactly 4 requests issue (addr 0..C), then imem_req_valid=0. inst_out=first instruction stays stable. Raising inst_ready resumes fetch at 0x10.
- imem_req_ready=0 for 5 cycles → imem_req_valid=1, addr 0x0 stable; on ready, fetch_pc advances to 0x4.
- 2 outstanding (0x8, 0xC), redirect_pc=0x100 → both responses dropped, no FIFO push; next inst_pc=0x100, request addrs resume 0x100, 0x104.
- Redirect in same cycle as a response and a pop → response dropped, pop honoured, inst_valid=0 next cycle, drop_cnt=outstanding-1.
- redirect_pc=0x102 → misalign_err=1 sticky, fetch at 0x100. Assert rst_n=0 mid-fetch → all outputs zero immediately, refetch from RESET_PC after release.
